// File: rtl/m_stage.sv
// m_stage: merges two 4-phase Send/Ack input channels into one 4-phase output
// channel through a one-entry data latch (DL). Every output is a register bit.
// Optional feature: define M_STAGE_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise channel a has fixed priority.
module m_stage #(
  parameter int W = 16
) (
  input  logic         CP,
  input  logic         MR,
  input  logic         Send_in_a,
  input  logic [W-1:0] PACKET_IN_A,
  output logic         Ack_out_a,
  input  logic         Send_in_b,
  input  logic [W-1:0] PACKET_IN_B,
  output logic         Ack_out_b,
  output logic         Send_out,
  input  logic         Ack_in,
  output logic [W-1:0] PACKET_OUT
);

  // Encodings chosen so each output is a single state bit (registered output).
  typedef enum logic [1:0] {
    I_IDLE  = 2'b00,
    I_ACK_A = 2'b01,
    I_ACK_B = 2'b10
  } istate_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'b00,
    O_SEND = 2'b01,
    O_REL  = 2'b10
  } ostate_t;

  istate_t        r_istate;
  istate_t        w_istate_nxt;
  ostate_t        r_ostate;
  ostate_t        w_ostate_nxt;
  logic [W-1:0]   r_dl;
  logic           r_last_b;    // 1: channel b captured most recently
  logic           w_cap;
  logic           w_grant_b;

  // Capture/arbitration decision for this edge
  always_comb begin
    w_cap = (r_istate == I_IDLE) && (r_ostate == O_IDLE) && (Send_in_a || Send_in_b);
`ifdef M_STAGE_RR_EN
    w_grant_b = Send_in_b && (!Send_in_a || !r_last_b);
`else
    w_grant_b = Send_in_b && !Send_in_a;
`endif
  end

  // State register, data latch and last-grant record
  always_ff @(posedge CP) begin
    if (MR) begin
      r_istate <= I_IDLE;
      r_ostate <= O_IDLE;
      r_dl     <= '0;
      r_last_b <= 1'b1;
    end else begin
      r_istate <= w_istate_nxt;
      r_ostate <= w_ostate_nxt;
      if (w_cap) begin
        r_dl     <= w_grant_b ? PACKET_IN_B : PACKET_IN_A;
        r_last_b <= w_grant_b;
      end
    end
  end

  // Next-state logic for the input and output FSMs
  always_comb begin
    w_istate_nxt = r_istate;
    w_ostate_nxt = r_ostate;
    case (r_istate)
      I_IDLE:  if (w_cap) w_istate_nxt = w_grant_b ? I_ACK_B : I_ACK_A;
      I_ACK_A: if (!Send_in_a) w_istate_nxt = I_IDLE;
      I_ACK_B: if (!Send_in_b) w_istate_nxt = I_IDLE;
      default: w_istate_nxt = I_IDLE;
    endcase
    case (r_ostate)
      O_IDLE:  if (w_cap) w_ostate_nxt = O_SEND;
      O_SEND:  if (Ack_in) w_ostate_nxt = O_REL;
      O_REL:   if (!Ack_in) w_ostate_nxt = O_IDLE;
      default: w_ostate_nxt = O_IDLE;
    endcase
  end

  // Outputs are direct register bits
  always_comb begin
    Ack_out_a  = r_istate[0];
    Ack_out_b  = r_istate[1];
    Send_out   = r_ostate[0];
    PACKET_OUT = r_dl;
  end

endmodule

// File: tb/tb_m_stage.sv
// tb_m_stage: scoreboard bench for m_stage (W=8). Expected packets are queued
// when stimulus is issued; a monitor pops and compares on each new Send_out.
module tb_m_stage;
  localparam int W = 8;

  logic         CP = 1'b0;
  logic         MR = 1'b1;
  logic         Send_in_a = 1'b0;
  logic [W-1:0] PACKET_IN_A = '0;
  logic         Ack_out_a;
  logic         Send_in_b = 1'b0;
  logic [W-1:0] PACKET_IN_B = '0;
  logic         Ack_out_b;
  logic         Send_out;
  logic         Ack_in = 1'b0;
  logic [W-1:0] PACKET_OUT;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];
  logic prev_send = 1'b0;

  m_stage #(.W(W)) dut (
    .CP(CP), .MR(MR),
    .Send_in_a(Send_in_a), .PACKET_IN_A(PACKET_IN_A), .Ack_out_a(Ack_out_a),
    .Send_in_b(Send_in_b), .PACKET_IN_B(PACKET_IN_B), .Ack_out_b(Ack_out_b),
    .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: each new Send_out presents one packet
  always @(negedge CP) begin
    if (Send_out === 1'b1 && !prev_send) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", PACKET_OUT);
      end else begin
        check("sb_packet", 32'(PACKET_OUT), 32'(sb_q.pop_front()));
      end
    end
    if (Ack_out_a === 1'b1 || Ack_out_b === 1'b1)
      check("acks_exclusive", 32'(Ack_out_a & Ack_out_b), 32'd0);
    prev_send = (Send_out === 1'b1);
  end

  task automatic do_reset();
    @(negedge CP);
    MR = 1'b1;
    Ack_in = 1'b0;
    @(negedge CP);
    check("rst_send_out", 32'(Send_out), 32'd0);
    check("rst_ack_a", 32'(Ack_out_a), 32'd0);
    check("rst_ack_b", 32'(Ack_out_b), 32'd0);
    check("rst_packet", 32'(PACKET_OUT), 32'd0);
    MR = 1'b0;
  endtask

  task automatic release_out();
    Ack_in = 1'b1;
    @(negedge CP);
    Ack_in = 1'b0;
    @(negedge CP);
    @(negedge CP);
  endtask

  initial begin
    int na, nb, ba, bb;
    bit done;

    // Reset, then capture on channel a on the first edge after MR
    do_reset();
    Send_in_a = 1'b1; PACKET_IN_A = 8'hA5; sb_q.push_back(8'hA5);
    @(negedge CP);
    check("a_send_out", 32'(Send_out), 32'd1);
    check("a_ack", 32'(Ack_out_a), 32'd1);
    check("a_packet", 32'(PACKET_OUT), 32'hA5);
    Send_in_a = 1'b0;
    @(negedge CP);
    check("a_ack_drop", 32'(Ack_out_a), 32'd0);
    check("a_send_hold", 32'(Send_out), 32'd1);

    // Backpressure: b waits while the output stage is busy
    Send_in_b = 1'b1; PACKET_IN_B = 8'h3C; sb_q.push_back(8'h3C);
    repeat (3) @(negedge CP);
    check("bp_ack_b", 32'(Ack_out_b), 32'd0);
    check("bp_packet", 32'(PACKET_OUT), 32'hA5);
    Ack_in = 1'b1;
    @(negedge CP);
    check("bp_send_clr", 32'(Send_out), 32'd0);
    check("bp_rel_ack_b", 32'(Ack_out_b), 32'd0);
    Ack_in = 1'b0;
    @(negedge CP);
    check("bp_idle_ack_b", 32'(Ack_out_b), 32'd0);
    @(negedge CP);
    check("b_ack", 32'(Ack_out_b), 32'd1);
    check("b_send_out", 32'(Send_out), 32'd1);
    check("b_packet", 32'(PACKET_OUT), 32'h3C);

    // Reset mid-handshake (O_SEND, Ack_out_b=1) discards the packet
    do_reset();
    Send_in_b = 1'b0;
    Send_in_a = 1'b1; PACKET_IN_A = 8'h5A; sb_q.push_back(8'h5A);
    @(negedge CP);
    check("post_rst_ack_a", 32'(Ack_out_a), 32'd1);
    check("post_rst_send", 32'(Send_out), 32'd1);
    check("post_rst_packet", 32'(PACKET_OUT), 32'h5A);
    Send_in_a = 1'b0;
    release_out();

    // Ack_in pulse while idle is ignored
    Ack_in = 1'b1;
    @(negedge CP);
    Ack_in = 1'b0;
    @(negedge CP);
    check("stray_ack_send", 32'(Send_out), 32'd0);
    Send_in_b = 1'b1; PACKET_IN_B = 8'h7E; sb_q.push_back(8'h7E);
    @(negedge CP);
    check("stray_ack_b", 32'(Ack_out_b), 32'd1);
    check("stray_send", 32'(Send_out), 32'd1);
    check("stray_packet", 32'(PACKET_OUT), 32'h7E);
    Send_in_b = 1'b0;
    release_out();

    // Both producers re-request continuously; downstream acks reactively
    do_reset();
    PACKET_IN_A = 8'h11; PACKET_IN_B = 8'h22;
`ifdef M_STAGE_RR_EN
    ba = 2; bb = 2;
    sb_q.push_back(8'h11); sb_q.push_back(8'h22);
    sb_q.push_back(8'h11); sb_q.push_back(8'h22);
`else
    ba = 3; bb = 1;
    sb_q.push_back(8'h11); sb_q.push_back(8'h11);
    sb_q.push_back(8'h11); sb_q.push_back(8'h22);
`endif
    na = 0; nb = 0; done = 1'b0;
    Send_in_a = 1'b1; Send_in_b = 1'b1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge CP);
      Ack_in = Send_out;
      if (Send_in_a && Ack_out_a) begin Send_in_a = 1'b0; na++; end
      else if (!Send_in_a && !Ack_out_a && na < ba) Send_in_a = 1'b1;
      if (Send_in_b && Ack_out_b) begin Send_in_b = 1'b0; nb++; end
      else if (!Send_in_b && !Ack_out_b && nb < bb) Send_in_b = 1'b1;
      if (na == ba && nb == bb && !Send_in_a && !Send_in_b && !Ack_out_a &&
          !Ack_out_b && !Send_out && !Ack_in && sb_q.size() == 0)
        done = 1'b1;
    end
    check("arb_seq_done", 32'(done), 32'd1);
    check("arb_count_a", 32'(na), 32'(ba));
    check("arb_count_b", 32'(nb), 32'(bb));

    repeat (3) @(negedge CP);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
